// File: rtl/ar_incoming_request_buffer.sv
// AXI AR request FIFO with an outstanding-burst limiter for read-response back-pressure.
// Optional zero-latency cut-through on an empty FIFO when AR_BYPASS_EN is defined.
module ar_incoming_request_buffer #(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 8,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_in_valid,
    output logic                  ar_in_ready,
    input  logic [ID_WIDTH-1:0]   ar_in_id,
    input  logic [ADDR_WIDTH-1:0] ar_in_addr,
    input  logic [7:0]            ar_in_len,
    input  logic [2:0]            ar_in_size,
    input  logic [1:0]            ar_in_burst,
    output logic                  ar_out_valid,
    input  logic                  ar_out_ready,
    output logic [ID_WIDTH-1:0]   ar_out_id,
    output logic [ADDR_WIDTH-1:0] ar_out_addr,
    output logic [7:0]            ar_out_len,
    output logic [2:0]            ar_out_size,
    output logic [1:0]            ar_out_burst,
    input  logic                  rsp_done,
    output logic [OW-1:0]         outstanding_count,
    output logic                  buffer_full,
    output logic                  outstanding_underflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_req_t;

    ar_req_t         mem [DEPTH];
    ar_req_t         in_req, head_req, out_req;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            underflow_q, underflow_d;
    logic            empty, full, out_full, fifo_valid, bypass, push, pop, issue;

    assign in_req   = '{id: ar_in_id, addr: ar_in_addr, len: ar_in_len,
                        size: ar_in_size, burst: ar_in_burst};
    assign head_req = mem[rd_ptr_q];

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign out_full   = (outst_q == OW'(MAX_OUTSTANDING));
    assign fifo_valid = ~empty & ~out_full;

`ifdef AR_BYPASS_EN
    assign bypass = empty & ar_in_valid & ar_out_ready & ~out_full;
`else
    assign bypass = 1'b0;
`endif

    assign ar_in_ready  = ~full;
    assign ar_out_valid = fifo_valid | bypass;
    // A cut-through request never touches the FIFO.
    assign push  = ar_in_valid & ar_in_ready & ~bypass;
    assign pop   = fifo_valid & ar_out_ready;
    assign issue = pop | bypass;

    assign out_req      = bypass ? in_req : head_req;
    assign ar_out_id    = out_req.id;
    assign ar_out_addr  = out_req.addr;
    assign ar_out_len   = out_req.len;
    assign ar_out_size  = out_req.size;
    assign ar_out_burst = out_req.burst;

    assign outstanding_count     = outst_q;
    assign buffer_full           = full;
    assign outstanding_underflow = underflow_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        outst_d     = outst_q;
        underflow_d = underflow_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({issue, rsp_done})
            2'b10: outst_d = outst_q + 1'b1;
            2'b01: begin
                if (outst_q == '0) underflow_d = 1'b1;
                else               outst_d = outst_q - 1'b1;
            end
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: entries are only visible once count says so.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_req;
    end
endmodule

// File: tb/tb_ar_incoming_request_buffer.sv
// Directed bench for ar_incoming_request_buffer: vector table plus hand-written corner sequences.
module tb_ar_incoming_request_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        ar_in_valid, ar_in_ready, ar_out_valid, ar_out_ready, rsp_done;
    logic [3:0]  ar_in_id, ar_out_id;
    logic [31:0] ar_in_addr, ar_out_addr;
    logic [7:0]  ar_in_len, ar_out_len;
    logic [2:0]  ar_in_size, ar_out_size;
    logic [1:0]  ar_in_burst, ar_out_burst;
    logic [3:0]  outstanding_count;
    logic        buffer_full, outstanding_underflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ar_incoming_request_buffer dut (
        .clk(clk), .rst(rst),
        .ar_in_valid(ar_in_valid), .ar_in_ready(ar_in_ready),
        .ar_in_id(ar_in_id), .ar_in_addr(ar_in_addr), .ar_in_len(ar_in_len),
        .ar_in_size(ar_in_size), .ar_in_burst(ar_in_burst),
        .ar_out_valid(ar_out_valid), .ar_out_ready(ar_out_ready),
        .ar_out_id(ar_out_id), .ar_out_addr(ar_out_addr), .ar_out_len(ar_out_len),
        .ar_out_size(ar_out_size), .ar_out_burst(ar_out_burst),
        .rsp_done(rsp_done), .outstanding_count(outstanding_count),
        .buffer_full(buffer_full), .outstanding_underflow(outstanding_underflow)
    );

    typedef struct {
        logic       vld;
        logic [3:0] id;
        logic       ordy;
        logic       rsp;
        logic       e_irdy;
        logic       e_ovld;
        logic [3:0] e_id;
        logic [3:0] e_oc;
        logic       e_full;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] addr_of(input logic [3:0] id);
        return 32'h1000 + 32'h40 * 32'(id);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [3:0] id, input logic ordy, input logic rsp);
        @(negedge clk);
        ar_in_valid  = v;
        ar_in_id     = id;
        ar_in_addr   = addr_of(id);
        ar_in_len    = {4'h0, id};
        ar_in_size   = 3'd2;
        ar_in_burst  = 2'b01;
        ar_out_ready = ordy;
        rsp_done     = rsp;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] id, input logic ordy, input logic rsp,
                                input logic irdy, input logic ovld, input logic [3:0] eid,
                                input logic [3:0] oc, input logic full);
        vec_t t;
        t = '{v, id, ordy, rsp, irdy, ovld, eid, oc, full};
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        ar_in_valid = 0; ar_in_id = 0; ar_in_addr = 0; ar_in_len = 0;
        ar_in_size = 0; ar_in_burst = 0; ar_out_ready = 0; rsp_done = 0;
        #12 rst = 1'b0;

        // Fill to full with ready low, try a 9th, then drain in order with rsp_done every cycle.
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 4'(i), 0, 0, 1, i > 0, 0, 0, 0));
        vecs.push_back(mk(1, 8, 0, 0, 0, 1, 0, 0, 1));
        for (int j = 0; j < 8; j++)
            vecs.push_back(mk(0, 0, 1, 1, j > 0, 1, 4'(j), 0, j == 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));

        foreach (vecs[k]) begin
            drive(vecs[k].vld, vecs[k].id, vecs[k].ordy, vecs[k].rsp);
            chk($sformatf("v%0d in_ready", k), 32'(ar_in_ready), 32'(vecs[k].e_irdy));
            chk($sformatf("v%0d out_valid", k), 32'(ar_out_valid), 32'(vecs[k].e_ovld));
            chk($sformatf("v%0d outstanding", k), 32'(outstanding_count), 32'(vecs[k].e_oc));
            chk($sformatf("v%0d full", k), 32'(buffer_full), 32'(vecs[k].e_full));
            if (vecs[k].e_ovld) begin
                chk($sformatf("v%0d out_id", k), 32'(ar_out_id), 32'(vecs[k].e_id));
                chk($sformatf("v%0d out_addr", k), ar_out_addr, addr_of(vecs[k].e_id));
                chk($sformatf("v%0d out_len", k), 32'(ar_out_len), 32'(vecs[k].e_id));
            end
        end

        // Saturation: 8 bursts issued with no responses, then release one slot.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1, 4'(k), k > 0, 0);
            chk($sformatf("sat%0d valid", k), 32'(ar_out_valid), 32'(k >= 1 && k <= 8));
            if (k >= 1 && k <= 8) chk($sformatf("sat%0d id", k), 32'(ar_out_id), 32'(k - 1));
        end
        drive(0, 0, 1, 0);
        chk("sat held valid", 32'(ar_out_valid), 0);
        chk("sat outstanding", 32'(outstanding_count), 8);
        drive(0, 0, 1, 1);
        chk("sat rsp cycle valid", 32'(ar_out_valid), 0);
        drive(0, 0, 1, 0);
        chk("sat reenable valid", 32'(ar_out_valid), 1);
        chk("sat reenable id", 32'(ar_out_id), 8);
        chk("sat reenable outst", 32'(outstanding_count), 7);
        drive(0, 0, 1, 0);
        chk("sat refull outst", 32'(outstanding_count), 8);
        chk("sat refull valid", 32'(ar_out_valid), 0);

        // count=1 simultaneous push/pop, then pop together with rsp_done.
        do_reset();
        drive(1, 3, 0, 0);
        drive(1, 5, 1, 0);
        chk("pp head id3", 32'(ar_out_id), 3);
        chk("pp valid", 32'(ar_out_valid), 1);
        drive(0, 0, 0, 0);
        chk("pp head id5", 32'(ar_out_id), 5);
        chk("pp valid after", 32'(ar_out_valid), 1);
        chk("pp outst", 32'(outstanding_count), 1);
        drive(0, 0, 1, 1);
        chk("pop+rsp id", 32'(ar_out_id), 5);
        drive(0, 0, 1, 0);
        chk("pop+rsp outst", 32'(outstanding_count), 1);
        chk("pop+rsp empty", 32'(ar_out_valid), 0);

        // Underflow flag is sticky; async reset mid-traffic clears everything.
        do_reset();
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("uf flag", 32'(outstanding_underflow), 1);
        chk("uf outst", 32'(outstanding_count), 0);
        for (int k = 0; k < 4; k++) drive(1, 4'(k), 0, 0);
        drive(0, 0, 0, 0);
        chk("uf still set", 32'(outstanding_underflow), 1);
        chk("4q valid", 32'(ar_out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst in_ready", 32'(ar_in_ready), 1);
        chk("arst out_valid", 32'(ar_out_valid), 0);
        chk("arst full", 32'(buffer_full), 0);
        chk("arst outst", 32'(outstanding_count), 0);
        chk("arst underflow", 32'(outstanding_underflow), 0);
        #2 rst = 1'b0;
        drive(0, 0, 1, 0);
        chk("post rst empty", 32'(ar_out_valid), 0);

        // Empty FIFO, ready high, id 9 arrives.
        do_reset();
        drive(1, 9, 1, 0);
`ifdef AR_BYPASS_EN
        chk("byp valid", 32'(ar_out_valid), 1);
        chk("byp id", 32'(ar_out_id), 9);
        drive(0, 0, 1, 0);
        chk("byp outst", 32'(outstanding_count), 1);
        chk("byp no entry", 32'(ar_out_valid), 0);
`else
        chk("nobyp valid", 32'(ar_out_valid), 0);
        drive(0, 0, 1, 0);
        chk("nobyp late valid", 32'(ar_out_valid), 1);
        chk("nobyp late id", 32'(ar_out_id), 9);
        chk("nobyp outst", 32'(outstanding_count), 0);
        drive(0, 0, 1, 0);
        chk("nobyp outst after", 32'(outstanding_count), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ar_incoming_request_buffer.md
Name: ar_incoming_request_buffer

Overview:
- DEPTH-entry FIFO for AXI AR requests on the incoming side.
- Accepts read-address requests from the AXI master and forwards them in order towards the ID-ordering / slave side.
- Keeps an outstanding-read counter so that no more than MAX_OUTSTANDING bursts are in flight. This provides back-pressure so the response path can never be oversubscribed.

Parameters:
- ID_WIDTH, 4, AR/R transaction ID width
- ADDR_WIDTH, 32, address width
- DEPTH, 8, FIFO entries (>=2)
- MAX_OUTSTANDING, 8, maximum issued-but-uncompleted bursts (>=1)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ar_in_valid  input  1  request valid from AXI master
- ar_in_ready  output  1  buffer can accept
- ar_in_id  input  ID_WIDTH  request ID
- ar_in_addr  input  ADDR_WIDTH  start address
- ar_in_len  input  8  beats minus one
- ar_in_size  input  3  beat size
- ar_in_burst  input  2  burst type
- ar_out_valid  output  1  request valid downstream
- ar_out_ready  input  1  downstream accepts
- ar_out_id / ar_out_addr / ar_out_len / ar_out_size / ar_out_burst  output  same widths  head request fields
- rsp_done  input  1  one-cycle pulse: final R beat (valid & ready & last) of one burst delivered to master
- outstanding_count  output  clog2(MAX_OUTSTANDING+1)  bursts in flight
- buffer_full  output  1  FIFO full
- outstanding_underflow  output  1  sticky error flag

Behaviour:
- Reset (async) values:
  - wr_ptr, rd_ptr, count, outstanding all 0.
  - outstanding_underflow = 0.
  - Outputs after reset: ar_in_ready=1, ar_out_valid=0, buffer_full=0, outstanding_count=0.
- Flags:
  - empty = (count==0); full = (count==DEPTH); buffer_full = full.
  - out_full = (outstanding==MAX_OUTSTANDING).
- Handshakes:
  - ar_in_ready = ~full.
  - ar_out_valid = ~empty & ~out_full.
  - push = ar_in_valid & ar_in_ready; pop = ar_out_valid & ar_out_ready.
- Data path:
  - ar_out_* is driven combinationally from mem[rd_ptr].
  - ar_out_* is don't-care while ar_out_valid=0, but must hold stable while valid=1 and ready=0.
- Latency: a push at edge N makes the entry visible with ar_out_valid=1 from cycle N+1 (given ~out_full). There is no same-cycle fall-through.
- Push: writes mem[wr_ptr]. wr_ptr wraps DEPTH-1 -> 0.
- Pop: rd_ptr wraps DEPTH-1 -> 0.
- count update:
  - +1 on push&~pop; -1 on ~push&pop.
  - Unchanged on both or neither.
  - Push and pop in the same cycle while full is impossible, because ready=0.
  - When count=1, a simultaneous push and pop keeps count=1 with the new entry at head next cycle.
- outstanding update:
  - +1 on pop&~rsp_done; -1 on ~pop&rsp_done; unchanged on both.
  - rsp_done while outstanding==0 and no pop: counter stays 0 and outstanding_underflow sets to 1. The flag is sticky until reset.
- Saturation: when out_full, ar_out_valid drops and the head is held. A rsp_done in that cycle re-enables ar_out_valid the next cycle.
- AXI rule: ar_out_valid never depends on ar_out_ready; it only changes on clock edges.
- Reset mid-operation: all queued entries are discarded, and the outputs return to their reset values immediately (asynchronously).

Optional Feature:
- Macro: AR_BYPASS_EN.
- Defined: zero-latency cut-through when the FIFO is empty.
  - Condition: empty & ar_in_valid & ar_out_ready & ~out_full.
  - ar_out_valid=1 and ar_out_* = ar_in_* combinationally.
  - No FIFO write; count and pointers unchanged; outstanding +1 (same rules as pop).
  - ar_in_ready is still ~full.
- Undefined: behaviour exactly as above, with minimum one-cycle latency.

Test Plan:
- After reset: ar_in_ready=1, ar_out_valid=0, outstanding_count=0, buffer_full=0.
- Push 8 requests (id 0..7, addr 0x1000+0x40*i) with ar_out_ready=0 -> buffer_full=1 and ar_in_ready=0 after the 8th. A 9th valid is not accepted.
- Then ar_out_ready=1 and rsp_done pulsing each cycle -> ids 0..7 emerge in order, the wrap-around is correct, and ar_out_valid=0 after the last.
- MAX_OUTSTANDING=8: issue 8 pops with no rsp_done, 2 more queued -> ar_out_valid=0 and outstanding_count=8. One rsp_done -> next cycle ar_out_valid=1; after the pop the count is back to 8.
- count=1 with a simultaneous push (id 5) and pop (id 3) -> id 3 leaves, id 5 is at head next cycle, count stays 1. A pop together with rsp_done leaves outstanding unchanged.
- rsp_done with outstanding=0 -> outstanding_underflow=1 and stays 1 until rst. Assert rst mid-traffic with 4 entries queued -> all outputs return to reset values asynchronously.
- AR_BYPASS_EN: with the FIFO empty and ready=1, ar_in id=9 -> ar_out_valid=1 and id=9 in the same cycle, count stays 0, outstanding +1. Without the macro, id=9 appears one cycle later.
